// File: rtl/dbus_demux4_pkg.sv
// Shared types and constants for the data-bus demultiplexer.
// Holds the FSM state enum, port geometry and the one-hot helper.
package bus_pkg;

    localparam int NPORTS = 4;
    localparam int SEL_W  = 2;

    localparam logic RSP_ERR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ERR
    } state_t;

    function automatic logic [NPORTS-1:0] onehot(
        input logic [SEL_W-1:0] s
    );
        return {{(NPORTS-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/dbus_demux4_if.sv
// Upstream load/store data-bus bundle.
// The core drives the request half; the demux drives the response half.
interface dbus_demux4_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dbus_demux4_timeout.sv
// Transaction watchdog: cleared on accept, counts while a slave is busy.
// o_expired fires on the cycle whose increment lands on TIMEOUT.
module dbus_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dbus_demux4.sv
// One-outstanding data-bus router from the LSU to four slave regions.
// Errors on disabled regions and on slaves that stall past TIMEOUT.
module dbus_demux4
    import bus_pkg::*;
#(
    parameter int unsigned SEL_LSB = 28,
    parameter logic [3:0]  PORT_EN = 4'b1111,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    dbus_demux4_if.slave        up,
    output logic [NPORTS-1:0]   s_valid,
    input  logic [NPORTS-1:0]   s_ready,
    output logic [31:0]         s_addr,
    output logic                s_we,
    output logic [31:0]         s_wdata,
    output logic [3:0]          s_wstrb,
    input  logic [NPORTS-1:0]   s_rvalid,
    input  logic [NPORTS*32-1:0] s_rdata
);

    state_t            r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [NPORTS-1:0] r_s_valid;
    logic [31:0]       r_s_addr;
    logic              r_s_we;
    logic [31:0]       r_s_wdata;
    logic [3:0]        r_s_wstrb;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;

    logic [SEL_W-1:0]  w_sel_in;
    logic [31:0]       w_rdata;
    logic              w_clr;
    logic              w_cnt_en;
    logic              w_expired;

    assign w_sel_in = up.req_addr[SEL_LSB +: SEL_W];
    assign w_clr    = (r_state == ST_IDLE) && up.req_valid;
    assign w_cnt_en = (r_state == ST_REQ) || (r_state == ST_RESP);

    always_comb begin
        w_rdata = '0;
        unique case (r_sel)
            2'd0: w_rdata = s_rdata[31:0];
            2'd1: w_rdata = s_rdata[63:32];
            2'd2: w_rdata = s_rdata[95:64];
            2'd3: w_rdata = s_rdata[127:96];
        endcase
    end

    dbus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_s_valid   <= '0;
            r_s_addr    <= '0;
            r_s_we      <= 1'b0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (up.req_valid) begin
                        r_sel     <= w_sel_in;
                        r_s_addr  <= up.req_addr;
                        r_s_we    <= up.req_we;
                        r_s_wdata <= up.req_wdata;
                        r_s_wstrb <= up.req_wstrb;
                        if (PORT_EN[w_sel_in]) begin
                            r_s_valid <= onehot(w_sel_in);
                            r_state   <= ST_REQ;
                        end else begin
                            r_state   <= ST_ERR;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_expired) begin
                        r_s_valid <= '0;
                        r_state   <= ST_ERR;
                    end else if (s_ready[r_sel]) begin
                        r_s_valid <= '0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // a completion on the expiry cycle still counts
                    if (s_rvalid[r_sel]) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_s_we ? 32'd0 : w_rdata;
                        r_state     <= ST_IDLE;
                    end else if (w_expired) begin
                        r_state     <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= RSP_ERR;
                    r_rsp_rdata <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign up.req_ready = (r_state == ST_IDLE);
    assign up.rsp_valid = r_rsp_valid;
    assign up.rsp_err   = r_rsp_err;
    assign up.rsp_rdata = r_rsp_rdata;
    assign s_valid      = r_s_valid;
    assign s_addr       = r_s_addr;
    assign s_we         = r_s_we;
    assign s_wdata      = r_s_wdata;
    assign s_wstrb      = r_s_wstrb;

endmodule
